// File: rtl/clock_counter.sv
// 24-hour BCD clock with a button-driven set-mode FSM.
// Optional alarm (hour/minute compare, two extra set states) enabled by defining ALARM_EN.
module clock_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode,
  input  logic       inc,
  output logic [7:0] hour,
  output logic [7:0] minute,
  output logic [7:0] second,
  output logic [2:0] set_sel,
  output logic       alarm_hit
);

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StSetHour = 3'd1,
    StSetMin  = 3'd2,
    StSetSec  = 3'd3
`ifdef ALARM_EN
    ,
    StSetAlHour = 3'd4,
    StSetAlMin  = 3'd5
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] minute_q, minute_d;
  logic [7:0] second_q, second_d;

  // Packed-BCD increment; units 9 rolls to 0 and bumps tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_wrap_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] r;
    if (v == max) begin
      r = 8'h00;
    end else begin
      r = bcd_inc(v);
    end
    return r;
  endfunction

`ifdef ALARM_EN
  logic [7:0] al_hour_q, al_hour_d;
  logic [7:0] al_min_q, al_min_d;
  logic       alarm_hit_q, alarm_hit_d;
`endif

  // Mode pulse always wins; inc is only honoured when no mode pulse is present.
  always_comb begin
    state_d = state_q;
    if (mode) begin
      unique case (state_q)
        StRun:     state_d = StSetHour;
        StSetHour: state_d = StSetMin;
        StSetMin:  state_d = StSetSec;
`ifdef ALARM_EN
        StSetSec:    state_d = StSetAlHour;
        StSetAlHour: state_d = StSetAlMin;
        StSetAlMin:  state_d = StRun;
`else
        StSetSec:  state_d = StRun;
`endif
        default:   state_d = StRun;
      endcase
    end
  end

  always_comb begin
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
`ifdef ALARM_EN
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
`endif
    unique case (state_q)
      StRun: begin
        if (tick) begin
          second_d = bcd_wrap_inc(second_q, 8'h59);
          if (second_q == 8'h59) begin
            minute_d = bcd_wrap_inc(minute_q, 8'h59);
            if (minute_q == 8'h59) begin
              hour_d = bcd_wrap_inc(hour_q, 8'h23);
            end
          end
        end
      end
      StSetHour: if (inc && !mode) hour_d = bcd_wrap_inc(hour_q, 8'h23);
      StSetMin:  if (inc && !mode) minute_d = bcd_wrap_inc(minute_q, 8'h59);
      StSetSec:  if (inc && !mode) second_d = 8'h00;
`ifdef ALARM_EN
      StSetAlHour: if (inc && !mode) al_hour_d = bcd_wrap_inc(al_hour_q, 8'h23);
      StSetAlMin:  if (inc && !mode) al_min_d = bcd_wrap_inc(al_min_q, 8'h59);
`endif
      default: ;
    endcase
  end

`ifdef ALARM_EN
  // Fires on the edge where a running tick lands exactly on alarm_hour:alarm_min:00.
  always_comb begin
    alarm_hit_d = (state_q == StRun) && tick &&
                  (hour_d == al_hour_q) && (minute_d == al_min_q) && (second_d == 8'h00);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      hour_q   <= 8'h00;
      minute_q <= 8'h00;
      second_q <= 8'h00;
`ifdef ALARM_EN
      al_hour_q   <= 8'h06;
      al_min_q    <= 8'h00;
      alarm_hit_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
`ifdef ALARM_EN
      al_hour_q   <= al_hour_d;
      al_min_q    <= al_min_d;
      alarm_hit_q <= alarm_hit_d;
`endif
    end
  end

  always_comb begin
    set_sel = 3'b000;
    unique case (state_q)
      StRun:     set_sel = 3'b000;
      StSetHour: set_sel = 3'b100;
      StSetMin:  set_sel = 3'b010;
      StSetSec:  set_sel = 3'b001;
`ifdef ALARM_EN
      StSetAlHour: set_sel = 3'b110;
      StSetAlMin:  set_sel = 3'b101;
`endif
      default:   set_sel = 3'b000;
    endcase
  end

  assign hour   = hour_q;
  assign minute = minute_q;
  assign second = second_q;

`ifdef ALARM_EN
  assign alarm_hit = alarm_hit_q;
`else
  assign alarm_hit = 1'b0;
`endif

endmodule

// File: tb/tb_clock_counter.sv
// Directed bench for clock_counter: vector table plus hand-written carry, set-mode and alarm cases.
module tb_clock_counter;

  logic       clk = 1'b0;
  logic       rst, tick, mode, inc;
  logic [7:0] hour, minute, second;
  logic [2:0] set_sel;
  logic       alarm_hit;

  int n_checks = 0;
  int n_fail   = 0;

  clock_counter dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .mode      (mode),
    .inc       (inc),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .set_sel   (set_sel),
    .alarm_hit (alarm_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, t, m, i;
    logic [7:0] h, mi, s;
    logic [2:0] sel;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic t, input logic m, input logic i);
    rst = r; tick = t; mode = m; inc = i;
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; mode = 1'b0; inc = 1'b0;
  endtask

  task automatic check(input string name, input logic [7:0] h, input logic [7:0] mi,
                       input logic [7:0] s, input logic [2:0] sel);
    n_checks++;
    if ({hour, minute, second, set_sel} !== {h, mi, s, sel}) begin
      n_fail++;
      $display("FAIL %s: got %h:%h:%h sel=%b, want %h:%h:%h sel=%b",
               name, hour, minute, second, set_sel, h, mi, s, sel);
    end
  endtask

  task automatic check_sel(input string name, input logic [2:0] sel);
    n_checks++;
    if (set_sel !== sel) begin
      n_fail++;
      $display("FAIL %s: got set_sel=%b, want %b", name, set_sel, sel);
    end
  endtask

  task automatic check_alarm(input string name, input logic exp);
    n_checks++;
    if (alarm_hit !== exp) begin
      n_fail++;
      $display("FAIL %s: got alarm_hit=%b, want %b", name, alarm_hit, exp);
    end
  endtask

  // From SET_SEC back to RUN, walking the alarm states when present.
  task automatic go_run();
`ifdef ALARM_EN
    step(0, 0, 1, 0);
    check_sel("sel_al_hour", 3'b110);
    step(0, 0, 1, 0);
    check_sel("sel_al_min", 3'b101);
`endif
    step(0, 0, 1, 0);
    check_sel("sel_run", 3'b000);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (h) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    repeat (m) step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    go_run();
    repeat (s) step(0, 1, 0, 0);
    check("set_time", bcd(h), bcd(m), bcd(s), 3'b000);
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; mode = 1'b0; inc = 1'b0;
    //            r  t  m  i    hour   min    sec    sel
    vecs[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b000};
    vecs[1]  = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 3'b000};
    vecs[2]  = '{0, 0, 0, 1, 8'h00, 8'h00, 8'h01, 3'b000};
    vecs[3]  = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 3'b100};
    vecs[4]  = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 3'b100};
    vecs[5]  = '{0, 0, 0, 1, 8'h01, 8'h00, 8'h01, 3'b100};
    vecs[6]  = '{0, 0, 0, 1, 8'h02, 8'h00, 8'h01, 3'b100};
    vecs[7]  = '{0, 0, 1, 1, 8'h02, 8'h00, 8'h01, 3'b010};
    vecs[8]  = '{0, 0, 0, 1, 8'h02, 8'h01, 8'h01, 3'b010};
    vecs[9]  = '{0, 0, 1, 0, 8'h02, 8'h01, 8'h01, 3'b001};
    vecs[10] = '{0, 1, 0, 1, 8'h02, 8'h01, 8'h00, 3'b001};
    vecs[11] = '{1, 1, 1, 1, 8'h00, 8'h00, 8'h00, 3'b000};
    vecs[12] = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 3'b000};
    vecs[13] = '{0, 1, 0, 0, 8'h00, 8'h00, 8'h02, 3'b000};

    @(negedge clk);
    step(1, 0, 0, 0);
    check("reset", 8'h00, 8'h00, 8'h00, 3'b000);
    check_alarm("reset_alarm", 1'b0);

    for (int k = 0; k < 14; k++) begin
      step(vecs[k].r, vecs[k].t, vecs[k].m, vecs[k].i);
      check($sformatf("vec%0d", k), vecs[k].h, vecs[k].mi, vecs[k].s, vecs[k].sel);
    end

    // Full-day wrap in a single edge.
    set_time(23, 59, 59);
    step(0, 1, 0, 0);
    check("wrap_midnight", 8'h00, 8'h00, 8'h00, 3'b000);

    set_time(12, 34, 9);
    step(0, 1, 0, 0);
    check("sec_units_carry", 8'h12, 8'h34, 8'h10, 3'b000);

    set_time(12, 59, 59);
    step(0, 1, 0, 0);
    check("hour_carry", 8'h13, 8'h00, 8'h00, 3'b000);

    set_time(9, 59, 59);
    step(0, 1, 0, 0);
    check("hour_tens_carry", 8'h10, 8'h00, 8'h00, 3'b000);

    // Hour edit wraps 23->00 with no carry, ticks frozen.
    set_time(22, 0, 0);
    step(0, 0, 1, 0);
    check("enter_set_hour", 8'h22, 8'h00, 8'h00, 3'b100);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    check("tick_frozen", 8'h23, 8'h00, 8'h00, 3'b100);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("hour_edit_wrap", 8'h01, 8'h00, 8'h00, 3'b100);
    step(0, 0, 1, 1);
    check("mode_beats_inc", 8'h01, 8'h00, 8'h00, 3'b010);

    // Minute edit wraps 59->00 without touching hour.
    set_time(5, 59, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check("min_edit_wrap", 8'h05, 8'h00, 8'h00, 3'b010);

    // Reset mid-edit discards it.
    set_time(0, 45, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("in_set_min", 8'h00, 8'h45, 8'h00, 3'b010);
    step(1, 0, 0, 0);
    check("rst_in_set_min", 8'h00, 8'h00, 8'h00, 3'b000);

    set_time(5, 59, 59);
    check_alarm("alarm_before", 1'b0);
    step(0, 1, 0, 0);
    check("alarm_time", 8'h06, 8'h00, 8'h00, 3'b000);
`ifdef ALARM_EN
    check_alarm("alarm_pulse", 1'b1);
`else
    check_alarm("alarm_absent", 1'b0);
`endif
    step(0, 0, 0, 0);
    check_alarm("alarm_one_clk", 1'b0);
    step(0, 1, 0, 0);
    check_alarm("alarm_next_tick", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_counter.md
CLOCK_COUNTER -- requirements
Module: clock_counter

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 tick  input  1  one-clk-wide 1 Hz enable pulse.
REQ-004 mode  input  1  one-clk-wide debounced button pulse; advances set-mode FSM.
REQ-005 inc  input  1  one-clk-wide debounced button pulse; increments the field selected by the FSM.
REQ-006 hour  output  8  packed BCD 00-23, tens in [7:4], units in [3:0], registered.
REQ-007 minute  output  8  packed BCD 00-59, registered.
REQ-008 second  output  8  packed BCD 00-59, registered.
REQ-009 set_sel  output  3  one-hot field under edit: [2] hour, [1] minute, [0] second; 000 in RUN.
REQ-010 alarm_hit  output  1  one-clk pulse when time equals the alarm setting; constant 0 without ALARM_EN.

Function
REQ-011 FSM states SHALL be RUN, SET_HOUR, SET_MIN, SET_SEC; with ALARM_EN also SET_AL_HOUR, SET_AL_MIN.
REQ-012 A mode pulse SHALL advance RUN->SET_HOUR->SET_MIN->SET_SEC->RUN; with ALARM_EN, SET_SEC->SET_AL_HOUR->SET_AL_MIN->RUN.
REQ-013 In RUN, a tick SHALL increment second; 59->00 carries into minute in the same cycle; minute 59->00 carries into hour; hour 23->00.
REQ-014 23:59:59 plus one tick SHALL give 00:00:00 in one clk, with no intermediate value visible on the outputs.
REQ-015 Outputs SHALL update on the clk edge that samples tick=1: latency one clk.
REQ-016 In any SET state, ticks SHALL be ignored and the time frozen.
REQ-017 inc in SET_HOUR SHALL increment hour only, 23->00, with no carry.
REQ-018 inc in SET_MIN SHALL increment minute only, 59->00, with no carry.
REQ-019 inc in SET_SEC SHALL clear second to 00.
REQ-020 inc in RUN SHALL be ignored.
REQ-021 mode and inc in the same clk: mode SHALL take effect and inc SHALL be ignored.
REQ-022 set_sel SHALL reflect the current state in the same clk as the state register; alarm states drive 110 (AL_HOUR) and 101 (AL_MIN).
REQ-023 Each BCD units digit SHALL roll 9->0 with a tens increment; digit values above 9 SHALL be unreachable.

Reset
REQ-024 rst SHALL force hour, minute and second to 00, state to RUN, set_sel to 000 and alarm_hit to 0, overriding tick, mode and inc in the same clk.
REQ-025 rst asserted during a SET state SHALL discard the edit and return to RUN.
REQ-026 With ALARM_EN, rst SHALL set the alarm to 06:00.

Configuration
REQ-027 Macro ALARM_EN: when defined, the block SHALL add alarm hour/minute BCD registers, the two alarm set states, and alarm_hit.
REQ-028 With ALARM_EN, alarm_hit SHALL pulse for one clk on the edge where, in RUN, a tick makes the time equal alarm_hour:alarm_min:00.
REQ-029 Without ALARM_EN, alarm_hit SHALL be tied to 0, the alarm registers and states SHALL be absent, and SET_SEC->RUN.

Verification
REQ-030 Time 23:59:59, one tick -> next clk outputs 8'h00/8'h00/8'h00.
REQ-031 Time 12:34:09, one tick -> second = 8'h10; time 12:59:59, tick -> 8'h13/8'h00/8'h00.
REQ-032 One mode pulse, three inc pulses from hour 8'h22 -> hour = 8'h01 and set_sel = 100; a tick during this -> no change.
REQ-033 mode and inc in the same clk while in SET_HOUR -> state = SET_MIN and hour unchanged.
REQ-034 rst during SET_MIN with minute 8'h45 -> outputs 00:00:00, set_sel = 000.
REQ-035 ALARM_EN, alarm 06:00, time 05:59:59, tick -> alarm_hit high for exactly 1 clk; without ALARM_EN -> alarm_hit stays 0.
